// File: rtl/ram_fifo_pkg.sv
// ram_fifo shared constants.
// Default geometry for the RAM-backed FIFO.
package ram_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);
endpackage

// File: rtl/ram_fifo_if.sv
// ram_fifo client bus.
// Master pushes/pops, slave is the FIFO.
interface ram_fifo_if
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  wren;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rden;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;

  modport master (
    output wren, wdata, rden,
    input  rdata, full, empty
  );

  modport slave (
    input  wren, wdata, rden,
    output rdata, full, empty
  );
endinterface

// File: rtl/ram_dp.sv
// Simple dual-port RAM: sync write, registered read.
// Only the read register is reset; the array is not.
module ram_dp
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int NUM = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read and write returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_fifo.sv
// RAM-backed synchronous FIFO.
// Pointers, occupancy and registered flags.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset_n,
  ram_fifo_if.slave  bus
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = bus.wren & ~full_q;
  assign rd_ok = bus.rden & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Flags are registered from the post-edge count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  assign bus.full  = full_q;
  assign bus.empty = empty_q;

  ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok),
    .waddr   (wr_ptr),
    .wdata   (bus.wdata),
    .re      (rd_ok),
    .raddr   (rd_ptr),
    .rdata   (bus.rdata)
  );

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo.
// Queue scoreboard predicts rdata and flags.
module tb_ram_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ram_fifo_if bus ();

  ram_fifo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0] sb [$];
  int         mcount = 0;
  logic [3:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rdata"}, 8'(bus.rdata), 8'(exp_rd));
    chk({tag, ".full"},  8'(bus.full),  8'(mcount == 16));
    chk({tag, ".empty"}, 8'(bus.empty), 8'(mcount == 0));
    chk({tag, ".excl"},  8'(bus.full & bus.empty), 8'd0);
  endtask

  task automatic step(input logic w, input logic [3:0] d,
                      input logic r, input string tag);
    logic mw;
    logic mr;
    bus.wren  = w;
    bus.wdata = d;
    bus.rden  = r;
    mw = w && (mcount != 16);
    mr = r && (mcount != 0);
    if (mr) exp_rd = sb.pop_front();
    if (mw) sb.push_back(d);
    if (mw && !mr) mcount++;
    if (mr && !mw) mcount--;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.wren  = 1'b1;
    bus.wdata = 4'h5;
    bus.rden  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, "fill");
    step(1'b1, 4'h7, 1'b0, "fill_drop");

    for (int i = 0; i < 17; i++) step(1'b0, 4'h0, 1'b1, "drain");
    chk("drain_hold", 8'(bus.rdata), 8'hF);

    for (int i = 0; i < 10; i++) step(1'b1, 4'(i + 3), 1'b0, "wrap_w1");
    for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b1, "wrap_r1");
    for (int i = 0; i < 16; i++) step(1'b1, 4'(15 - i), 1'b0, "wrap_w2");
    for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 1'b1, "wrap_r2");

    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 8), 1'b0, "sim_pre");
    for (int i = 0; i < 20; i++) step(1'b1, 4'($urandom), 1'b1, "sim5");
    chk("sim5_count", 8'(mcount), 8'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1, "sim_drain");
    step(1'b1, 4'h9, 1'b1, "sim_empty");
    for (int i = 0; i < 15; i++) step(1'b1, 4'(i), 1'b0, "sim_fill");
    step(1'b1, 4'h3, 1'b1, "sim_full");
    for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 1'b1, "sim_out");

    for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 1), 1'b0, "mid_fill");
    step(1'b0, 4'h0, 1'b1, "mid_rd");
    step(1'b1, 4'hE, 1'b0, "mid_top");
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    mcount = 0;
    exp_rd = '0;
    check_all("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 4'hA, 1'b0, "post_w1");
    step(1'b1, 4'hB, 1'b0, "post_w2");
    step(1'b0, 4'h0, 1'b1, "post_r1");
    chk("post_first", 8'(bus.rdata), 8'hA);
    step(1'b0, 4'h0, 1'b1, "post_r2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
